// File: rtl/cpu_event_sequencer.sv
// cpu_event_sequencer: CPU T-state sequencer with ready/stall handling,
// interrupt arbitration (RESET > NMI > IRQ), forced-BRK injection,
// set-overflow pulse generation and T-state overflow lock.
module cpu_event_sequencer #(
  parameter int NUM_IRQ = 4,
  parameter int T_W     = 3
) (
  input  logic               CLK,
  input  logic               nRESET,
  input  logic               CLK_en,
  input  logic               READY_pin,
  input  logic               RnW,
  input  logic               NEXT_T,
  input  logic               VEC_ACK,
  input  logic               nNMI,
  input  logic [NUM_IRQ-1:0] nIRQ,
  input  logic [NUM_IRQ-1:0] IRQ_EN,
  input  logic               I_FLAG,
  input  logic               nSO,
  output logic [T_W-1:0]     T_STATE,
  output logic               SYNC,
  output logic               READY,
  output logic               FORCE_BRK,
  output logic               PC_INC,
  output logic [1:0]         INT_VEC,
  output logic [2:0]         INT_SRC,
  output logic               SO_REQ,
  output logic               LOCKED
);

  localparam logic [T_W-1:0] TMAX = '1;
  localparam logic [T_W-1:0] T1   = T_W'(1);

  typedef enum logic [1:0] {
    VEC_IRQ = 2'b00,
    VEC_NMI = 2'b01,
    VEC_RST = 2'b10
  } vec_e;

  logic [T_W-1:0] t_q, t_d;
  logic           ready_q, ready_d;
  logic           locked_q, locked_d;
  logic           nmi_pend_q, nmi_pend_d;
  logic           reset_pend_q, reset_pend_d;
  logic           int_active_q, int_active_d;
  vec_e           vec_q, vec_d;
  logic [2:0]     src_q, src_d;
  logic           nmi_smp_q, nmi_smp_d;
  logic           so_smp_q, so_smp_d;
  logic           so_req_q, so_req_d;

  logic           advance;
  logic           boundary;
  logic           ack;
  logic           nmi_fall;
  logic           irq_hit;
  logic [2:0]     irq_idx;

  assign advance  = CLK_en & ready_q & ~locked_q;
  assign boundary = advance & NEXT_T & ~int_active_q;
  assign ack      = advance & VEC_ACK & int_active_q;
  assign nmi_fall = CLK_en & nmi_smp_q & ~nNMI;

  // Lowest-index enabled, asserted IRQ channel wins; scanned high-to-low so
  // the last match is the lowest index.
  always_comb begin
    irq_hit = 1'b0;
    irq_idx = '0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (~nIRQ[i-1] & IRQ_EN[i-1] & ~I_FLAG) begin
        irq_hit = 1'b1;
        irq_idx = 3'(i - 1);
      end
    end
  end

  // Next-state logic for T-state, edge detectors, pending flags and arbitration.
  always_comb begin
    t_d          = t_q;
    ready_d      = READY_pin | ~RnW;
    locked_d     = locked_q;
    nmi_pend_d   = nmi_pend_q;
    reset_pend_d = reset_pend_q;
    int_active_d = int_active_q;
    vec_d        = vec_q;
    src_d        = src_q;
    nmi_smp_d    = nmi_smp_q;
    so_smp_d     = so_smp_q;
    so_req_d     = so_req_q;

    if (advance) begin
      if (NEXT_T)
        t_d = '0;
      else if (t_q == '0)
        t_d = T1;
      else if (t_q == TMAX)
        locked_d = 1'b1;
      else
        t_d = t_q + T1;
    end

    // Edge samplers run on every enabled cycle, independent of READY.
    if (CLK_en) begin
      nmi_smp_d = nNMI;
      so_smp_d  = nSO;
      so_req_d  = so_smp_q & ~nSO;
    end

    if (ack) begin
      int_active_d = 1'b0;
      if (vec_q == VEC_NMI) nmi_pend_d   = 1'b0;
      if (vec_q == VEC_RST) reset_pend_d = 1'b0;
    end
    // A fresh NMI edge must survive a same-cycle acknowledge.
    if (nmi_fall) nmi_pend_d = 1'b1;

    if (boundary) begin
      if (reset_pend_q) begin
        int_active_d = 1'b1;
        vec_d        = VEC_RST;
        src_d        = '0;
      end else if (nmi_pend_q) begin
        int_active_d = 1'b1;
        vec_d        = VEC_NMI;
        src_d        = '0;
      end else if (irq_hit) begin
        int_active_d = 1'b1;
        vec_d        = VEC_IRQ;
        src_d        = irq_idx;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      t_q          <= T1;
      ready_q      <= 1'b1;
      locked_q     <= 1'b0;
      nmi_pend_q   <= 1'b0;
      reset_pend_q <= 1'b1;
      int_active_q <= 1'b1;
      vec_q        <= VEC_RST;
      src_q        <= '0;
      nmi_smp_q    <= 1'b1;
      so_smp_q     <= 1'b1;
      so_req_q     <= 1'b0;
    end else begin
      t_q          <= t_d;
      ready_q      <= ready_d;
      locked_q     <= locked_d;
      nmi_pend_q   <= nmi_pend_d;
      reset_pend_q <= reset_pend_d;
      int_active_q <= int_active_d;
      vec_q        <= vec_d;
      src_q        <= src_d;
      nmi_smp_q    <= nmi_smp_d;
      so_smp_q     <= so_smp_d;
      so_req_q     <= so_req_d;
    end
  end

  assign T_STATE   = t_q;
  assign SYNC      = (t_q == T1) & ~locked_q;
  assign READY     = ready_q;
  assign FORCE_BRK = int_active_q & (t_q == T1);
  assign PC_INC    = ~FORCE_BRK;
  assign INT_VEC   = vec_q;
  assign INT_SRC   = src_q;
  assign SO_REQ    = so_req_q;
  assign LOCKED    = locked_q;

endmodule
